// File: rtl/svi_cas_pkg.sv
// Shared definitions for the SVI-328 cassette reader and writer.
package svi_cas_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEADER,
        ST_SYNC,
        ST_DATA
    } framer_state_t;

    localparam logic [7:0]  HDR_FILL = 8'h55;
    localparam logic [7:0]  HDR_SYNC = 8'h7F;
    localparam int          HDR_LEN  = 17;

    localparam int          DEF_CLK_HZ      = 42_660_000;
    localparam int          DEF_SHORT_MAX   = 26_663;
    localparam int          DEF_GAP_MIN     = 53_325;
    localparam int          DEF_LEADER_BITS = 16;
    localparam logic [20:0] CAS_ADDR_LAST   = 21'h1FFFFF;
endpackage

// File: rtl/cas_bit_decoder.sv
// FSK demodulator: synchronizes tape_out, times rising-edge periods and turns
// them into bits (long = '0', short pair = '1'); flags gaps and motor-off.
module cas_bit_decoder
    import svi_cas_pkg::*;
#(
    parameter int SHORT_MAX = DEF_SHORT_MAX,
    parameter int GAP_MIN   = DEF_GAP_MIN
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic tape_out,
    input  logic motor_on,
    output logic bit_valid,
    output logic bit_val,
    output logic gap
);
    localparam logic [16:0] SHORT_C = 17'(SHORT_MAX);
    localparam logic [16:0] GAP_C   = 17'(GAP_MIN);

    logic [2:0]  sync_q;
    logic        rise_q;
    logic [16:0] per_q;
    logic        half_q;
    logic        is_short;

    // per_q holds the cycle count since the previous rising edge; it starts
    // saturated so the very first edge after idle never yields a bit.
    assign gap      = (per_q == GAP_C) || !motor_on;
    assign is_short = per_q <= SHORT_C;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync_q    <= '0;
            rise_q    <= 1'b0;
            per_q     <= GAP_C;
            half_q    <= 1'b0;
            bit_valid <= 1'b0;
            bit_val   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], tape_out};
            rise_q    <= sync_q[1] & ~sync_q[2];
            bit_valid <= 1'b0;
            if (rise_q) begin
                per_q <= 17'd1;
                if (gap) begin
                    half_q <= 1'b0;
                end else if (is_short) begin
                    if (half_q) begin
                        bit_valid <= 1'b1;
                        bit_val   <= 1'b1;
                    end
                    half_q <= !half_q;
                end else begin
                    // a pending lone short is dropped; the long still counts
                    bit_valid <= 1'b1;
                    bit_val   <= 1'b0;
                    half_q    <= 1'b0;
                end
            end else begin
                if (per_q != GAP_C) per_q <= per_q + 17'd1;
                if (gap) half_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/cas_writer.sv
// Cassette recorder: frames demodulated bytes and writes them to the CAS SDRAM
// region. Define CAS_HEADER_EN to insert the 17-byte block header per leader.
//
// state     | meaning
// ST_IDLE   | no signal (gap or motor off)
// ST_LEADER | counting consecutive '1' bits
// ST_SYNC   | leader seen, waiting for a start bit (header queued here)
// ST_DATA   | shifting in 8 data bits MSB first
module cas_writer
    import svi_cas_pkg::*;
#(
    parameter int          CLK_HZ      = DEF_CLK_HZ,
    parameter int          SHORT_MAX   = DEF_SHORT_MAX,
    parameter int          GAP_MIN     = DEF_GAP_MIN,
    parameter int          LEADER_BITS = DEF_LEADER_BITS,
    parameter logic [20:0] ADDR_LAST   = CAS_ADDR_LAST
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        tape_out,
    input  logic        motor_on,
    input  logic        rewind,
    output logic [20:0] sdram_addr,
    output logic [7:0]  sdram_data,
    output logic        sdram_wr,
    input  logic        sdram_available,
    input  logic        sdram_ready,
    output logic [20:0] byte_count,
    output logic [2:0]  status
);
    localparam int            LW        = $clog2(LEADER_BITS + 1);
    localparam logic [LW-1:0] LEAD_LAST = LW'(LEADER_BITS - 1);

    if (CLK_HZ <= 0 || SHORT_MAX >= GAP_MIN || GAP_MIN >= 2**17 || LEADER_BITS < 1) begin : g_bad_cfg
        $error("cas_writer: inconsistent timing parameters");
    end

    framer_state_t state_q, state_d;
    logic          bit_valid, bit_val, gap, clear;
    logic [LW-1:0] lead_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q, push_data;
    logic          byte_rdy_q, push, hdr_busy;
    logic [7:0]    fifo_mem [4];
    logic [1:0]    wr_ptr_q, rd_ptr_q;
    logic [2:0]    fill_q;
    logic          fifo_empty, fifo_full, pop, push_ok;
    logic          wr_q, full_q, ovf_q;
    logic [20:0]   addr_q, count_q;
    logic [7:0]    data_q;

    assign clear = reset || rewind;

    cas_bit_decoder #(.SHORT_MAX(SHORT_MAX), .GAP_MIN(GAP_MIN)) u_dec (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .tape_out (tape_out),
        .motor_on (motor_on),
        .bit_valid(bit_valid),
        .bit_val  (bit_val),
        .gap      (gap)
    );

`ifdef CAS_HEADER_EN
    logic [4:0] hdr_cnt_q;
    logic       hdr_push;
    assign hdr_busy = hdr_cnt_q != 5'd0;

    always_ff @(posedge clk_sys) begin
        if (clear || gap)                                   hdr_cnt_q <= 5'd0;
        else if (state_q == ST_LEADER && state_d == ST_SYNC) hdr_cnt_q <= 5'(HDR_LEN);
        else if (hdr_push)                                  hdr_cnt_q <= hdr_cnt_q - 5'd1;
    end
`else
    assign hdr_busy = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (clear) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (gap) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_LEADER;
                ST_LEADER: if (bit_valid && bit_val && lead_cnt_q == LEAD_LAST) state_d = ST_SYNC;
                ST_SYNC:   if (bit_valid && !bit_val && !hdr_busy) state_d = ST_DATA;
                ST_DATA:   if (bit_valid && bit_cnt_q == 3'd7) state_d = ST_SYNC;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Header bytes wait for FIFO space, so the framer simply stalls in SYNC.
    always_comb begin
        push      = byte_rdy_q;
        push_data = shreg_q;
`ifdef CAS_HEADER_EN
        hdr_push  = 1'b0;
        if (!byte_rdy_q && state_q == ST_SYNC && hdr_busy && !fifo_full) begin
            hdr_push  = 1'b1;
            push      = 1'b1;
            push_data = (hdr_cnt_q == 5'd1) ? HDR_SYNC : HDR_FILL;
        end
`endif
    end

    always_ff @(posedge clk_sys) begin
        if (clear || gap) begin
            lead_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'd0;
            byte_rdy_q <= 1'b0;
        end else begin
            byte_rdy_q <= 1'b0;
            if (bit_valid) begin
                case (state_q)
                    ST_LEADER: lead_cnt_q <= (bit_val && lead_cnt_q != LEAD_LAST) ? lead_cnt_q + LW'(1) : '0;
                    ST_SYNC:   bit_cnt_q  <= 3'd0;
                    ST_DATA: begin
                        shreg_q    <= {shreg_q[6:0], bit_val};
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        byte_rdy_q <= bit_cnt_q == 3'd7;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Once full, queued bytes are popped and discarded rather than written.
    assign fifo_empty = fill_q == 3'd0;
    assign fifo_full  = fill_q == 3'd4;
    assign pop        = !wr_q && !fifo_empty && (sdram_available || full_q);
    assign push_ok    = push && !full_q && (!fifo_full || pop);

    always_ff @(posedge clk_sys) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk_sys) begin
        if (clear) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            fill_q   <= 3'd0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
            fill_q <= fill_q + {2'b00, push_ok} - {2'b00, pop};
            if (push && !full_q && fifo_full && !pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (clear) begin
            wr_q    <= 1'b0;
            addr_q  <= 21'd0;
            count_q <= 21'd0;
            data_q  <= 8'd0;
            full_q  <= 1'b0;
        end else if (wr_q) begin
            if (sdram_ready) begin
                wr_q    <= 1'b0;
                count_q <= count_q + 21'd1;
                if (addr_q == ADDR_LAST) full_q <= 1'b1;
                else                     addr_q <= addr_q + 21'd1;
            end
        end else if (pop && !full_q) begin
            wr_q   <= 1'b1;
            data_q <= fifo_mem[rd_ptr_q];
        end
    end

    assign sdram_addr = addr_q;
    assign sdram_data = data_q;
    assign sdram_wr   = wr_q;
    assign byte_count = count_q;
    assign status     = {ovf_q, full_q, (state_q != ST_IDLE) || !fifo_empty};
endmodule
